// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS encodings for the ID/EX stage: ALU operation codes, opcode/funct
// constants and the operand forwarding-source select.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID fields, forwarding sources, flush, and the
// registered EX-side outputs plus the load-use stall back to ID.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]        id_alu_control;
  logic              id_alu_src, id_reg_dst, id_reg_write;
  logic              id_mem_read, id_mem_write, id_mem_to_reg;

  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_data;
  logic              flush;

  logic [DATA_W-1:0] A, B, ex_store_data;
  logic [3:0]        Alu_control;
  logic [REG_AW-1:0] ex_dest;
  logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic              stall;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alu_control, id_alu_src, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data, flush,
    input  A, B, ex_store_data, Alu_control, ex_dest,
           ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alu_control, id_alu_src, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data, flush,
    output A, B, ex_store_data, Alu_control, ex_dest,
           ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall
  );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding select for one EX source register; EX/MEM beats MEM/WB and
// register 0 is never forwarded.
module fwd_unit
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_idx,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  output fwd_sel_e          sel
);

  always_comb begin
    sel = FWD_REG;
    if (src_idx != '0) begin
      if (exmem_reg_write && exmem_rd == src_idx)
        sel = FWD_EXMEM;
      else if (memwb_reg_write && memwb_rd == src_idx)
        sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, MEM/WB write-through on
// capture and EX-side operand forwarding. Pure steering, no arithmetic.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic   clk,
  input logic   rst,
  id_ex_if.slave bus
);

  logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic              ex_alu_src;
  logic [3:0]        ex_alu_control;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_dest;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic              stall, bubble;
  logic [DATA_W-1:0] cap_rs_data, cap_rt_data;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  fwd_sel_e          sel_rs, sel_rt;

  assign stall = ex_valid && ex_mem_read && (ex_dest != '0) && bus.id_valid &&
                 ((ex_dest == bus.id_rs) || (ex_dest == bus.id_rt));
  assign bubble = bus.flush || stall;

  // Register file writes this cycle are not yet visible in the read data.
  assign cap_rs_data = (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == bus.id_rs)
                       ? bus.memwb_data : bus.id_rs_data;
  assign cap_rt_data = (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == bus.id_rt)
                       ? bus.memwb_data : bus.id_rt_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_alu_src     <= 1'b0;
      ex_alu_control <= 4'b0000;
      ex_rs          <= '0;
      ex_rt          <= '0;
      ex_dest        <= '0;
      ex_rs_data     <= '0;
      ex_rt_data     <= '0;
      ex_imm         <= '0;
    end else begin
      ex_valid       <= bus.id_valid && !bubble;
      ex_reg_write   <= bus.id_reg_write && !bubble;
      ex_mem_read    <= bus.id_mem_read && !bubble;
      ex_mem_write   <= bus.id_mem_write && !bubble;
      ex_mem_to_reg  <= bus.id_mem_to_reg;
      ex_alu_src     <= bus.id_alu_src;
      ex_alu_control <= bus.id_alu_control;
      ex_rs          <= bus.id_rs;
      ex_rt          <= bus.id_rt;
      ex_dest        <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      ex_rs_data     <= cap_rs_data;
      ex_rt_data     <= cap_rt_data;
      ex_imm         <= bus.id_imm;
    end
  end

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_rs (
    .src_idx(ex_rs), .exmem_reg_write(bus.exmem_reg_write), .exmem_rd(bus.exmem_rd),
    .memwb_reg_write(bus.memwb_reg_write), .memwb_rd(bus.memwb_rd), .sel(sel_rs)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_rt (
    .src_idx(ex_rt), .exmem_reg_write(bus.exmem_reg_write), .exmem_rd(bus.exmem_rd),
    .memwb_reg_write(bus.memwb_reg_write), .memwb_rd(bus.memwb_rd), .sel(sel_rt)
  );

  always_comb begin
    fwd_rs = ex_rs_data;
    fwd_rt = ex_rt_data;
    case (sel_rs)
      FWD_EXMEM: fwd_rs = bus.exmem_result;
      FWD_MEMWB: fwd_rs = bus.memwb_data;
      default:   fwd_rs = ex_rs_data;
    endcase
    case (sel_rt)
      FWD_EXMEM: fwd_rt = bus.exmem_result;
      FWD_MEMWB: fwd_rt = bus.memwb_data;
      default:   fwd_rt = ex_rt_data;
    endcase
  end

  assign bus.A             = fwd_rs;
  assign bus.B             = ex_alu_src ? ex_imm : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.Alu_control   = ex_alu_control;
  assign bus.ex_dest       = ex_dest;
  assign bus.ex_valid      = ex_valid;
  assign bus.ex_reg_write  = ex_reg_write;
  assign bus.ex_mem_read   = ex_mem_read;
  assign bus.ex_mem_write  = ex_mem_write;
  assign bus.ex_mem_to_reg = ex_mem_to_reg;
  assign bus.stall         = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard/forwarding scenarios, then
// random traffic against a behavioural model of the ID/EX boundary.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_if #(.DATA_W(DW), .REG_AW(AW)) bus ();
  id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic          rst, flush, id_valid;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic [3:0]    alu;
    logic          alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
    logic          ex_we;
    logic [AW-1:0] ex_rd;
    logic [DW-1:0] ex_res;
    logic          wb_we;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
  } stim_t;

  // What the instruction sitting in EX looks like in the model.
  typedef struct packed {
    logic          valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    logic [AW-1:0] rs, rt, dest;
    logic [DW-1:0] rs_val, rt_val, imm;
    logic [3:0]    alu;
  } ex_t;

  typedef struct packed {
    logic [DW-1:0] a, b, store;
    logic [3:0]    alu;
    logic [AW-1:0] dest;
    logic          valid, reg_write, mem_read, mem_write, mem_to_reg, stall;
  } exp_t;

  exp_t exp_q[$];
  ex_t  m;
  int   checks = 0;
  int   failures = 0;

  function automatic logic [DW-1:0] operand(stim_t s, logic [AW-1:0] idx, logic [DW-1:0] held);
    if (idx == 0) return held;
    if (s.ex_we && s.ex_rd == idx) return s.ex_res;
    if (s.wb_we && s.wb_rd == idx) return s.wb_data;
    return held;
  endfunction

  function automatic logic [DW-1:0] read_port(stim_t s, logic [AW-1:0] idx, logic [DW-1:0] rf);
    return (s.wb_we && idx != 0 && s.wb_rd == idx) ? s.wb_data : rf;
  endfunction

  function automatic logic load_use(ex_t e, stim_t s);
    return e.valid && e.mem_read && e.dest != 0 && s.id_valid && (e.dest == s.rs || e.dest == s.rt);
  endfunction

  task automatic apply(stim_t s);
    rst                 = s.rst;
    bus.flush           = s.flush;
    bus.id_valid        = s.id_valid;
    bus.id_rs           = s.rs;
    bus.id_rt           = s.rt;
    bus.id_rd           = s.rd;
    bus.id_rs_data      = s.rs_data;
    bus.id_rt_data      = s.rt_data;
    bus.id_imm          = s.imm;
    bus.id_alu_control  = s.alu;
    bus.id_alu_src      = s.alu_src;
    bus.id_reg_dst      = s.reg_dst;
    bus.id_reg_write    = s.reg_write;
    bus.id_mem_read     = s.mem_read;
    bus.id_mem_write    = s.mem_write;
    bus.id_mem_to_reg   = s.mem_to_reg;
    bus.exmem_reg_write = s.ex_we;
    bus.exmem_rd        = s.ex_rd;
    bus.exmem_result    = s.ex_res;
    bus.memwb_reg_write = s.wb_we;
    bus.memwb_rd        = s.wb_rd;
    bus.memwb_data      = s.wb_data;
  endtask

  // Drive one cycle's inputs, queue what EX must show this cycle, advance the model.
  task automatic step(stim_t s);
    exp_t e;
    ex_t  n;
    logic kill;
    @(posedge clk);
    #1;
    apply(s);
    e.a          = operand(s, m.rs, m.rs_val);
    e.store      = operand(s, m.rt, m.rt_val);
    e.b          = m.alu_src ? m.imm : e.store;
    e.alu        = m.alu;
    e.dest       = m.dest;
    e.valid      = m.valid;
    e.reg_write  = m.reg_write;
    e.mem_read   = m.mem_read;
    e.mem_write  = m.mem_write;
    e.mem_to_reg = m.mem_to_reg;
    e.stall      = load_use(m, s);
    exp_q.push_back(e);
    kill         = s.flush || e.stall;
    n.valid      = s.id_valid && !kill;
    n.reg_write  = s.reg_write && !kill;
    n.mem_read   = s.mem_read && !kill;
    n.mem_write  = s.mem_write && !kill;
    n.mem_to_reg = s.mem_to_reg;
    n.alu_src    = s.alu_src;
    n.rs         = s.rs;
    n.rt         = s.rt;
    n.dest       = s.reg_dst ? s.rd : s.rt;
    n.rs_val     = read_port(s, s.rs, s.rs_data);
    n.rt_val     = read_port(s, s.rt, s.rt_data);
    n.imm        = s.imm;
    n.alu        = s.alu;
    m = s.rst ? '0 : n;
  endtask

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("A", bus.A, e.a);
        chk("B", bus.B, e.b);
        chk("store_data", bus.ex_store_data, e.store);
        chk("alu_control", DW'(bus.Alu_control), DW'(e.alu));
        chk("ex_dest", DW'(bus.ex_dest), DW'(e.dest));
        chk("ex_valid", DW'(bus.ex_valid), DW'(e.valid));
        chk("ex_reg_write", DW'(bus.ex_reg_write), DW'(e.reg_write));
        chk("ex_mem_read", DW'(bus.ex_mem_read), DW'(e.mem_read));
        chk("ex_mem_write", DW'(bus.ex_mem_write), DW'(e.mem_write));
        chk("ex_mem_to_reg", DW'(bus.ex_mem_to_reg), DW'(e.mem_to_reg));
        chk("stall", DW'(bus.stall), DW'(e.stall));
      end
    end
  end

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst        = ($urandom_range(0, 39) == 0);
    s.flush      = ($urandom_range(0, 7) == 0);
    s.id_valid   = ($urandom_range(0, 5) != 0);
    s.rs         = AW'($urandom_range(0, 3));
    s.rt         = AW'($urandom_range(0, 3));
    s.rd         = AW'($urandom_range(0, 3));
    s.rs_data    = $urandom;
    s.rt_data    = $urandom;
    s.imm        = $urandom;
    s.alu        = 4'($urandom);
    s.alu_src    = 1'($urandom);
    s.reg_dst    = 1'($urandom);
    s.reg_write  = 1'($urandom);
    s.mem_read   = ($urandom_range(0, 2) == 0);
    s.mem_write  = 1'($urandom);
    s.mem_to_reg = 1'($urandom);
    s.ex_we      = 1'($urandom);
    s.ex_rd      = AW'($urandom_range(0, 3));
    s.ex_res     = $urandom;
    s.wb_we      = 1'($urandom);
    s.wb_rd      = AW'($urandom_range(0, 3));
    s.wb_data    = $urandom;
    return s;
  endfunction

  initial begin : stimulus
    stim_t s, idle, lw, use_r4;
    idle = '0;
    s = idle;
    s.rst = 1'b1;
    apply(s);
    m = '0;
    step(s);
    step(idle);

    // add r3, r1, r2
    s = idle; s.id_valid = 1; s.rs = 1; s.rt = 2; s.rd = 3; s.rs_data = 5; s.rt_data = 7;
    s.alu = 4'b0010; s.reg_dst = 1; s.reg_write = 1;
    step(s);
    step(idle);

    // EX/MEM and MEM/WB both target r2 read as rs
    s = idle; s.id_valid = 1; s.rs = 2; s.rs_data = 32'h1;
    step(s);
    s = idle; s.ex_we = 1; s.ex_rd = 2; s.ex_res = 32'h10; s.wb_we = 1; s.wb_rd = 2; s.wb_data = 32'h20;
    step(s);
    s = idle; s.id_valid = 1; s.rs = 2; s.rs_data = 32'h1;
    step(s);
    s = idle; s.wb_we = 1; s.wb_rd = 2; s.wb_data = 32'h20; s.ex_rd = 2; s.ex_res = 32'h10;
    step(s);

    // lw r4 then a use of r4: stall, bubble, stall clears
    lw = idle; lw.id_valid = 1; lw.rs = 1; lw.rt = 4; lw.mem_read = 1; lw.mem_to_reg = 1;
    lw.reg_write = 1; lw.alu = 4'b0010; lw.alu_src = 1; lw.imm = 32'h8;
    use_r4 = idle; use_r4.id_valid = 1; use_r4.rs = 4; use_r4.rt = 5; use_r4.rd = 6;
    use_r4.reg_dst = 1; use_r4.reg_write = 1; use_r4.alu = 4'b0110;
    step(lw);
    step(use_r4);
    step(use_r4);
    step(use_r4);

    // flush kills a store entering EX
    s = idle; s.flush = 1; s.id_valid = 1; s.mem_write = 1; s.reg_write = 1; s.rt = 7;
    step(s);
    step(idle);

    // r0 is never forwarded
    s = idle; s.id_valid = 1; s.rs = 0; s.rt = 0; s.wb_we = 1; s.wb_rd = 0; s.wb_data = 32'hFF;
    step(s);
    s = idle; s.ex_we = 1; s.ex_rd = 0; s.ex_res = 32'hAB; s.wb_we = 1; s.wb_rd = 0; s.wb_data = 32'hFF;
    step(s);

    // reset while stalled and flushing
    step(lw);
    s = use_r4; s.rst = 1; s.flush = 1;
    step(s);
    step(idle);
    step(idle);

    for (int i = 0; i < 3000; i++) step(rand_stim());

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter REG_AW, default 5, register-index width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 id_valid  input  1  ID holds a real instruction.
REQ-006 id_rs, id_rt, id_rd  input  REG_AW each  decoded register indices.
REQ-007 id_rs_data, id_rt_data  input  DATA_W each  register-file read data.
REQ-008 id_imm  input  DATA_W  sign/zero-extended immediate.
REQ-009 id_alu_control  input  4  ALU operation code (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, XOR 1101).
REQ-010 id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  input  1 each  decoded controls.
REQ-011 exmem_reg_write, exmem_rd, exmem_result  input  1/REG_AW/DATA_W  EX/MEM forwarding source.
REQ-012 memwb_reg_write, memwb_rd, memwb_data  input  1/REG_AW/DATA_W  MEM/WB forwarding and writeback source.
REQ-013 flush  input  1  taken branch/jump; kill instruction entering EX.
REQ-014 A, B  output  DATA_W each  ALU operands.
REQ-015 Alu_control  output  4  registered ALU operation.
REQ-016 ex_store_data  output  DATA_W  forwarded rt value for sw/sh/sb.
REQ-017 ex_dest  output  REG_AW  destination: rd if reg_dst else rt.
REQ-018 ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  output  1 each  registered controls.
REQ-019 stall  output  1  load-use hazard; ID and PC SHALL hold while high.

Function
REQ-020 Pipeline latency SHALL be exactly one cycle: ID fields captured on an edge appear on EX outputs that cycle.
REQ-021 stall SHALL be combinational = ex_valid & ex_mem_read & ex_dest!=0 & id_valid & (ex_dest==id_rs | ex_dest==id_rt).
REQ-022 On flush or stall, the register SHALL load a bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write cleared; flush takes priority, result identical.
REQ-023 Capture write-through: if memwb_reg_write & memwb_rd!=0 & memwb_rd==id_rs, latched rs data SHALL be memwb_data (likewise rt).
REQ-024 A forwarding SHALL select exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs; else memwb_data under the same MEM/WB condition; else latched rs data.
REQ-025 EX/MEM SHALL win over MEM/WB when both match.
REQ-026 Register 0 SHALL never be forwarded; A/B source for index 0 is latched data.
REQ-027 B SHALL be ex_imm when ex_alu_src=1, else forwarded rt; ex_store_data SHALL always be forwarded rt.
REQ-028 Forwarding SHALL apply regardless of ex_valid; bubbles carry harmless operands.
REQ-029 No arithmetic SHALL occur in this block; widths pass through unchanged.

Reset
REQ-030 While rst is high on an edge, all registered fields SHALL clear to 0 (Alu_control 0000, ex_dest 0, ex_valid 0); rst overrides flush and stall.
REQ-031 After reset, A=B=ex_store_data=0 and stall=0 unless forwarding inputs drive otherwise.
REQ-032 Reset mid-stall SHALL leave a bubble; no instruction is retained.

Structure
REQ-033 mips_pkg SHALL hold Alu_control encodings, opcode/funct constants and the forwarding-select enum (FWD_REG, FWD_EXMEM, FWD_MEMWB).
REQ-034 Forwarding selection SHALL be one combinational sub-module, fwd_unit, instantiated twice (rs, rt).

Verification
REQ-035 add r3 captured with rs_data=5, rt_data=7, alu_src=0 -> next cycle A=5, B=7, Alu_control=0010, ex_dest=3, ex_valid=1.
REQ-036 ex_rs=2, exmem_rd=2 result 0x10, memwb_rd=2 data 0x20, both writing -> A=0x10; drop exmem_reg_write -> A=0x20.
REQ-037 EX holds lw to r4 (valid), ID instruction uses rs=4 -> stall=1; next edge ex_valid=0, ex_mem_read=0; stall falls.
REQ-038 flush=1 with id_valid=1 -> next cycle ex_valid=0, ex_reg_write=0, ex_mem_write=0.
REQ-039 memwb writes r0 data 0xFF, exmem_rd=0 writing, ex_rs=0 latched 0 -> A=0.
REQ-040 rst=1 while stall=1 and flush=1 -> next cycle all registered outputs 0, stall=0.
